// File: rtl/aes_dec_mmio.sv
// rtl/aes_dec_mmio.sv - bus front end for the AES-128 inverse-cipher core
// Holds key/ciphertext, sequences one core run, captures plaintext with timeout.
module aes_dec_mmio #(
  parameter int TIMEOUT = 63
) (
  input  logic         clock,
  input  logic         reset,
  input  logic [5:0]   bus_addr,
  input  logic         bus_we,
  input  logic         bus_re,
  input  logic [31:0]  bus_wdata,
  output logic [31:0]  bus_rdata,
  output logic         bus_rvalid,
  output logic [127:0] core_secret,
  output logic [127:0] core_cipher,
  output logic         core_we,
  input  logic         core_busy,
  input  logic [127:0] core_plaintext,
  output logic         irq
);
  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [1:0] {IDLE, ISSUE, RUN} state_t;

  state_t         state, state_nx;
  logic [CW-1:0]  cnt, cnt_nx;
  logic [127:0]   key, ct, pt;
  logic           irq_en, done, err;
  logic           fsm_done, fsm_err;
  logic [31:0]    key_w, ct_w, pt_w, rd_mux;

  logic [3:0] word;
  assign word = bus_addr[5:2];

  logic unused_addr_bits;
  assign unused_addr_bits = ^bus_addr[1:0];

  logic busy, sel_key, sel_ct, sel_ctrl, sel_status;
  assign busy       = (state != IDLE);
  assign sel_key    = (word[3:2] == 2'b00);
  assign sel_ct     = (word[3:2] == 2'b01);
  assign sel_ctrl   = (word == 4'hC);
  assign sel_status = (word == 4'hD);

  // A start is refused while we run or while the core is still finishing
  // a job it was given before a reset.
  logic start_req, start_ok, prot_err;
  assign start_req = bus_we & sel_ctrl & bus_wdata[0];
  assign start_ok  = start_req & ~busy & ~core_busy;
  assign prot_err  = (bus_we & (sel_key | sel_ct) & busy) | (start_req & ~start_ok);

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    core_we  = 1'b0;
    fsm_done = 1'b0;
    fsm_err  = 1'b0;
    case (state)
      IDLE: if (start_ok) state_nx = ISSUE;
      ISSUE: begin
        core_we  = 1'b1;
        cnt_nx   = CW'(TIMEOUT);
        state_nx = RUN;
      end
      RUN: begin
        if (!core_busy) begin
          fsm_done = 1'b1;
          state_nx = IDLE;
        end else if (cnt == '0) begin
          fsm_err  = 1'b1;
          state_nx = IDLE;
        end else begin
          cnt_nx = cnt - 1'b1;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    key_w = '0;
    ct_w  = '0;
    pt_w  = '0;
    for (int i = 0; i < 4; i++) begin
      if (word[1:0] == i[1:0]) begin
        key_w = key[127-32*i -: 32];
        ct_w  = ct[127-32*i -: 32];
        pt_w  = pt[127-32*i -: 32];
      end
    end
    rd_mux = '0;
    case (word[3:2])
      2'b00: rd_mux = key_w;
      2'b01: rd_mux = ct_w;
      2'b10: rd_mux = pt_w;
      default: begin
        if (sel_ctrl)   rd_mux = {30'd0, irq_en, 1'b0};
        if (sel_status) rd_mux = {29'd0, err, done, busy};
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= '0;
      key        <= '0;
      ct         <= '0;
      pt         <= '0;
      irq_en     <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
      bus_rdata  <= '0;
      bus_rvalid <= 1'b0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      for (int i = 0; i < 4; i++) begin
        if (bus_we && !busy && word[1:0] == i[1:0]) begin
          if (sel_key) key[127-32*i -: 32] <= bus_wdata;
          if (sel_ct)  ct[127-32*i -: 32]  <= bus_wdata;
        end
      end
      if (fsm_done) pt <= core_plaintext;
      if (bus_we && sel_ctrl) irq_en <= bus_wdata[1];
      // Hardware set beats a W1C clear landing on the same edge.
      if (fsm_done)
        done <= 1'b1;
      else if (start_ok || (bus_we && sel_status && bus_wdata[1]))
        done <= 1'b0;
      if (fsm_err || prot_err)
        err <= 1'b1;
      else if (bus_we && sel_status && bus_wdata[2])
        err <= 1'b0;
      bus_rvalid <= bus_re;
      if (bus_re) bus_rdata <= rd_mux;
    end
  end

  assign core_secret = key;
  assign core_cipher = ct;
  assign irq         = done & irq_en;

endmodule

// File: tb/tb_aes_dec_mmio.sv
// tb/tb_aes_dec_mmio.sv - scoreboard bench for aes_dec_mmio with a stub core
module tb_aes_dec_mmio;
  localparam logic [127:0] FIPS_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] FIPS_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] FIPS_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT2      = 128'h0f1e2d3c4b5a69788796a5b4c3d2e1f0;
  localparam logic [5:0] A_KEY = 6'h00, A_CT = 6'h10, A_PT = 6'h20;
  localparam logic [5:0] A_CTRL = 6'h30, A_STATUS = 6'h34;

  logic         clock = 1'b0;
  logic         reset = 1'b1;
  logic [5:0]   bus_addr = '0;
  logic         bus_we = 1'b0;
  logic         bus_re = 1'b0;
  logic [31:0]  bus_wdata = '0;
  logic [31:0]  bus_rdata;
  logic         bus_rvalid;
  logic [127:0] core_secret, core_cipher;
  logic         core_we;
  logic         core_busy = 1'b0;
  logic [127:0] core_plaintext = '0;
  logic         irq;

  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] exp_q[$];
  logic [127:0] exp_pt;

  aes_dec_mmio #(.TIMEOUT(63)) dut (
    .clock(clock), .reset(reset),
    .bus_addr(bus_addr), .bus_we(bus_we), .bus_re(bus_re), .bus_wdata(bus_wdata),
    .bus_rdata(bus_rdata), .bus_rvalid(bus_rvalid),
    .core_secret(core_secret), .core_cipher(core_cipher), .core_we(core_we),
    .core_busy(core_busy), .core_plaintext(core_plaintext), .irq(irq)
  );

  always #5 clock = ~clock;

  // Stub core: busy for stub_lat cycles after core_we (forever when stuck),
  // knows the FIPS-197 vector and returns ~ct for anything else.
  logic         stub_stuck = 1'b0;
  int           stub_lat = 4;
  int           stub_cnt = 0;
  int           we_count = 0;
  logic [127:0] stub_key = '0, stub_ct = '0;
  always @(posedge clock) begin
    if (core_we) begin
      we_count       <= we_count + 1;
      core_busy      <= 1'b1;
      stub_cnt       <= stub_lat;
      stub_key       <= core_secret;
      stub_ct        <= core_cipher;
      core_plaintext <= '1;
    end else if (core_busy && !stub_stuck) begin
      if (stub_cnt <= 1) begin
        core_busy      <= 1'b0;
        core_plaintext <= (stub_key == FIPS_KEY && stub_ct == FIPS_CT) ? FIPS_PT : ~stub_ct;
      end else begin
        stub_cnt <= stub_cnt - 1;
      end
    end
  end

  function automatic logic [31:0] word_of(input logic [127:0] v, input int i);
    return v[127-32*i -: 32];
  endfunction

  // Bus tasks are entered and left at a falling edge.
  task automatic bus_write(input logic [5:0] a, input logic [31:0] d);
    bus_addr = a; bus_wdata = d; bus_we = 1'b1;
    @(negedge clock);
    bus_we = 1'b0;
  endtask

  task automatic bus_read(input logic [5:0] a, output logic [31:0] d);
    bus_addr = a; bus_re = 1'b1;
    @(negedge clock);
    bus_re = 1'b0;
    d = bus_rdata;
  endtask

  task automatic load_key_ct(input logic [127:0] k, input logic [127:0] c);
    for (int i = 0; i < 4; i++) bus_write(A_KEY + 6'(4*i), word_of(k, i));
    for (int i = 0; i < 4; i++) bus_write(A_CT + 6'(4*i), word_of(c, i));
  endtask

  task automatic wait_idle(input string tag);
    logic [31:0] s;
    int n = 0;
    do begin
      bus_read(A_STATUS, s);
      n++;
    end while (s[0] && n < 300);
    n_cmp++;
    if (s[0]) begin
      n_err++;
      $display("FAIL %s_idle_wait: busy=%0d after %0d polls, required 0", tag, s[0], n);
    end
  endtask

  task automatic wait_core_idle(input string tag);
    int n = 0;
    while (core_busy && n < 300) begin
      @(negedge clock);
      n++;
    end
    n_cmp++;
    if (core_busy) begin
      n_err++;
      $display("FAIL %s_core_wait: core_busy=1 after %0d cycles, required 0", tag, n);
    end
  endtask

  task automatic test_reset();
    logic [31:0] got, e;
    reset = 1'b1;
    repeat (2) @(negedge clock);
    n_cmp++;
    if ({core_we, bus_rvalid, irq} !== 3'b000 || bus_rdata !== 32'd0) begin
      n_err++;
      $display("FAIL reset_outputs: got we/rv/irq=%b rdata=%h required 000/00000000",
               {core_we, bus_rvalid, irq}, bus_rdata);
    end
    reset = 1'b0;
    for (int a = 0; a < 16; a++) exp_q.push_back(32'd0);
    for (int a = 0; a < 16; a++) begin
      bus_read(6'(4*a), got);
      e = exp_q.pop_front();
      n_cmp++;
      if (got !== e || bus_rvalid !== 1'b1) begin
        n_err++;
        $display("FAIL reset_read@%h: got %h rvalid %b required %h rvalid 1", 6'(4*a), got, bus_rvalid, e);
      end
    end
    @(negedge clock);
    n_cmp++;
    if (bus_rvalid !== 1'b0) begin
      n_err++;
      $display("FAIL rvalid_drop: got %b required 0", bus_rvalid);
    end
  endtask

  task automatic test_rw();
    logic [31:0] got, e;
    bus_write(A_KEY, 32'ha5a5a5a5);
    exp_q.push_back(32'ha5a5a5a5);
    bus_addr = A_KEY; bus_wdata = 32'h5a5a5a5a; bus_we = 1'b1; bus_re = 1'b1;
    @(negedge clock);
    bus_we = 1'b0; bus_re = 1'b0; got = bus_rdata;
    e = exp_q.pop_front();
    n_cmp++;
    if (got !== e) begin
      n_err++;
      $display("FAIL rw_same_cycle: got %h required %h", got, e);
    end
    exp_q.push_back(32'h5a5a5a5a);
    bus_read(A_KEY, got);
    e = exp_q.pop_front();
    n_cmp++;
    if (got !== e) begin
      n_err++;
      $display("FAIL rw_readback: got %h required %h", got, e);
    end
  endtask

  task automatic test_fips();
    logic [31:0] got, e;
    int w0;
    load_key_ct(FIPS_KEY, FIPS_CT);
    for (int i = 0; i < 4; i++) exp_q.push_back(word_of(FIPS_KEY, i));
    for (int i = 0; i < 4; i++) exp_q.push_back(word_of(FIPS_CT, i));
    for (int i = 0; i < 8; i++) begin
      bus_read(6'(4*i), got);
      e = exp_q.pop_front();
      n_cmp++;
      if (got !== e) begin
        n_err++;
        $display("FAIL fips_keyct%0d: got %h required %h", i, got, e);
      end
    end
    w0 = we_count;
    bus_write(A_CTRL, 32'h1);
    n_cmp++;
    if (core_we !== 1'b1) begin
      n_err++;
      $display("FAIL fips_core_we_issue: got %b required 1", core_we);
    end
    exp_q.push_back(32'h1);
    bus_read(A_STATUS, got);
    e = exp_q.pop_front();
    n_cmp++;
    if (got !== e || core_we !== 1'b0) begin
      n_err++;
      $display("FAIL fips_status_busy: got %h core_we %b required %h core_we 0", got, core_we, e);
    end
    wait_idle("fips");
    n_cmp++;
    if (we_count - w0 !== 1) begin
      n_err++;
      $display("FAIL fips_we_pulses: got %0d required 1", we_count - w0);
    end
    bus_write(A_PT, 32'hdeadbeef);
    for (int i = 0; i < 4; i++) exp_q.push_back(word_of(FIPS_PT, i));
    exp_q.push_back(32'h2);
    for (int i = 0; i < 5; i++) begin
      bus_read((i < 4) ? A_PT + 6'(4*i) : A_STATUS, got);
      e = exp_q.pop_front();
      n_cmp++;
      if (got !== e) begin
        n_err++;
        $display("FAIL fips_result%0d: got %h required %h", i, got, e);
      end
    end
    exp_pt = FIPS_PT;
  endtask

  task automatic test_protect();
    logic [31:0] got, e;
    int w0;
    stub_lat = 20;
    bus_write(A_STATUS, 32'h6);
    load_key_ct(FIPS_KEY, CT2);
    w0 = we_count;
    bus_write(A_CTRL, 32'h1);
    bus_write(A_KEY, 32'hffffffff);
    bus_write(A_CTRL, 32'h1);
    n_cmp++;
    if (core_secret !== FIPS_KEY || core_cipher !== CT2) begin
      n_err++;
      $display("FAIL prot_core_inputs: got %h/%h required %h/%h", core_secret, core_cipher, FIPS_KEY, CT2);
    end
    wait_idle("prot");
    n_cmp++;
    if (we_count - w0 !== 1) begin
      n_err++;
      $display("FAIL prot_we_pulses: got %0d required 1", we_count - w0);
    end
    exp_pt = ~CT2;
    exp_q.push_back(32'h00010203);
    exp_q.push_back(32'h6);
    for (int i = 0; i < 4; i++) exp_q.push_back(word_of(exp_pt, i));
    for (int i = 0; i < 6; i++) begin
      bus_read((i == 0) ? A_KEY : (i == 1) ? A_STATUS : A_PT + 6'(4*(i-2)), got);
      e = exp_q.pop_front();
      n_cmp++;
      if (got !== e) begin
        n_err++;
        $display("FAIL prot_read%0d: got %h required %h", i, got, e);
      end
    end
    bus_write(A_STATUS, 32'h6);
    exp_q.push_back(32'h0);
    bus_read(A_STATUS, got);
    e = exp_q.pop_front();
    n_cmp++;
    if (got !== e) begin
      n_err++;
      $display("FAIL prot_w1c: got %h required %h", got, e);
    end
    stub_lat = 4;
  endtask

  task automatic test_irq();
    logic [31:0] got, e;
    int n = 0;
    bus_write(A_CTRL, 32'h2);
    exp_q.push_back(32'h2);
    bus_read(A_CTRL, got);
    e = exp_q.pop_front();
    n_cmp++;
    if (got !== e || irq !== 1'b0) begin
      n_err++;
      $display("FAIL irq_ctrl_read: got %h irq %b required %h irq 0", got, irq, e);
    end
    bus_write(A_CTRL, 32'h3);
    while (!irq && n < 200) begin
      @(negedge clock);
      n++;
    end
    exp_q.push_back(32'h2);
    bus_read(A_STATUS, got);
    e = exp_q.pop_front();
    n_cmp++;
    if (got !== e || n >= 200) begin
      n_err++;
      $display("FAIL irq_with_done: got status %h after %0d cycles required %h", got, n, e);
    end
    n_cmp++;
    if (irq !== 1'b1) begin
      n_err++;
      $display("FAIL irq_high: got %b required 1", irq);
    end
    bus_write(A_STATUS, 32'h2);
    n_cmp++;
    if (irq !== 1'b0) begin
      n_err++;
      $display("FAIL irq_clear: got %b required 0", irq);
    end
    bus_write(A_CTRL, 32'h0);
  endtask

  task automatic test_collision();
    logic [31:0] got, e;
    int n = 0;
    bus_write(A_STATUS, 32'h6);
    bus_write(A_CTRL, 32'h1);
    @(negedge clock);
    while (core_busy && n < 200) begin
      @(negedge clock);
      n++;
    end
    bus_write(A_STATUS, 32'h2);
    exp_q.push_back(32'h2);
    bus_read(A_STATUS, got);
    e = exp_q.pop_front();
    n_cmp++;
    if (got !== e || n >= 200) begin
      n_err++;
      $display("FAIL collision_done: got %h after %0d cycles required %h", got, n, e);
    end
  endtask

  task automatic test_timeout();
    logic [31:0] got, e, s;
    int k = 0;
    bus_write(A_STATUS, 32'h6);
    stub_stuck = 1'b1;
    bus_write(A_CTRL, 32'h1);
    do begin
      bus_read(A_STATUS, s);
      if (s[0]) k++;
    end while (s[0] && k < 200);
    n_cmp++;
    if (k !== 65) begin
      n_err++;
      $display("FAIL timeout_cycles: got %0d required 65", k);
    end
    n_cmp++;
    if (s !== 32'h4) begin
      n_err++;
      $display("FAIL timeout_status: got %h required 00000004", s);
    end
    for (int i = 0; i < 4; i++) exp_q.push_back(word_of(exp_pt, i));
    for (int i = 0; i < 4; i++) begin
      bus_read(A_PT + 6'(4*i), got);
      e = exp_q.pop_front();
      n_cmp++;
      if (got !== e) begin
        n_err++;
        $display("FAIL timeout_pt%0d: got %h required %h", i, got, e);
      end
    end
    stub_stuck = 1'b0;
    wait_core_idle("timeout");
  endtask

  task automatic test_async_reset();
    logic [31:0] got, e;
    int w0;
    bus_write(A_STATUS, 32'h6);
    stub_stuck = 1'b1;
    bus_write(A_CTRL, 32'h3);
    repeat (5) @(negedge clock);
    #2 reset = 1'b1;
    #1;
    n_cmp++;
    if ({core_we, irq, bus_rvalid} !== 3'b000 || core_secret !== '0) begin
      n_err++;
      $display("FAIL areset_immediate: got we/irq/rv=%b secret=%h required 000/0",
               {core_we, irq, bus_rvalid}, core_secret);
    end
    @(negedge clock);
    reset = 1'b0;
    for (int i = 0; i < 14; i++) exp_q.push_back(32'h0);
    for (int i = 0; i < 14; i++) begin
      bus_read(6'(4*i), got);
      e = exp_q.pop_front();
      n_cmp++;
      if (got !== e) begin
        n_err++;
        $display("FAIL areset_read@%h: got %h required %h", 6'(4*i), got, e);
      end
    end
    w0 = we_count;
    bus_write(A_CTRL, 32'h1);
    exp_q.push_back(32'h4);
    bus_read(A_STATUS, got);
    e = exp_q.pop_front();
    n_cmp++;
    if (got !== e || we_count !== w0) begin
      n_err++;
      $display("FAIL areset_refused: got status %h pulses %0d required %h pulses 0", got, we_count - w0, e);
    end
    stub_stuck = 1'b0;
    wait_core_idle("areset");
    bus_write(A_STATUS, 32'h4);
    load_key_ct(FIPS_KEY, FIPS_CT);
    bus_write(A_CTRL, 32'h1);
    n_cmp++;
    if (core_we !== 1'b1) begin
      n_err++;
      $display("FAIL areset_restart_we: got %b required 1", core_we);
    end
    wait_idle("areset");
    for (int i = 0; i < 4; i++) exp_q.push_back(word_of(FIPS_PT, i));
    exp_q.push_back(32'h2);
    for (int i = 0; i < 5; i++) begin
      bus_read((i < 4) ? A_PT + 6'(4*i) : A_STATUS, got);
      e = exp_q.pop_front();
      n_cmp++;
      if (got !== e) begin
        n_err++;
        $display("FAIL areset_result%0d: got %h required %h", i, got, e);
      end
    end
  endtask

  initial begin
    test_reset();
    test_rw();
    test_fips();
    test_protect();
    test_irq();
    test_collision();
    test_timeout();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
